// File: rtl/ball_frame_sequencer.sv
// ball_frame_sequencer
// Per-frame ball motion controller. Each vsync rising edge starts a fixed
// SAMPLE -> MOVE_X -> MOVE_Y -> COMMIT sequence. Position and hit flags only
// change at COMMIT, so the renderer never sees a half-updated position.
//
// Ports:
//   clk           pixel clock
//   reset         synchronous, active-high reset
//   vsync         vertical sync, active-high; rising edge starts a frame update
//   mode_auto     1 = autonomous bounce, 0 = manual buttons (latched in SAMPLE)
//   up/down       manual Y controls (up wins when both are set)
//   left/right    manual X controls (left wins when both are set)
//   ball_hpos     committed ball X (left edge)
//   ball_vpos     committed ball Y (top edge)
//   busy          high while the sequence is running
//   frame_done    one-cycle pulse when a new position is committed
//   hit_h/hit_v   last committed frame clamped on the X / Y axis
//   bounce_count  axis clamps since reset, wraps modulo 256
module ball_frame_sequencer #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned BALL_SIZE = 8,
  parameter int unsigned SPEED     = 2,
  parameter int unsigned H_INIT    = 320,
  parameter int unsigned V_INIT    = 240
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       mode_auto,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic [9:0] ball_hpos,
  output logic [9:0] ball_vpos,
  output logic       busy,
  output logic       frame_done,
  output logic       hit_h,
  output logic       hit_v,
  output logic [7:0] bounce_count
);

  localparam int unsigned POS_W  = 10;
  localparam int unsigned STEP_W = POS_W + 1;
  localparam int unsigned CNT_W  = 8;

  localparam logic signed [STEP_W-1:0] STEP  = STEP_W'(SPEED);
  localparam logic signed [STEP_W-1:0] X_MAX = STEP_W'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [STEP_W-1:0] Y_MAX = STEP_W'(V_ACTIVE - BALL_SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_MOVE_X,
    S_MOVE_Y,
    S_COMMIT
  } state_t;

  state_t                   r_state;
  logic                     r_vsync;
  logic                     r_auto;
  logic                     r_hdir;   // 1 = moving right
  logic                     r_vdir;   // 1 = moving down
  logic signed [STEP_W-1:0] r_dx;
  logic signed [STEP_W-1:0] r_dy;
  logic        [POS_W-1:0]  r_nx;
  logic        [POS_W-1:0]  r_ny;
  logic                     r_hx;
  logic                     r_hy;

  logic                     w_rise;
  logic signed [STEP_W-1:0] w_sum_x;
  logic signed [STEP_W-1:0] w_sum_y;

  // Rising-edge detect and unclamped candidate positions.
  assign w_rise  = vsync & ~r_vsync;
  assign w_sum_x = $signed({1'b0, ball_hpos}) + r_dx;
  assign w_sum_y = $signed({1'b0, ball_vpos}) + r_dy;

  // Frame sequencer: single registered FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_vsync      <= 1'b1;   // vsync already high at release is not an edge
      r_auto       <= 1'b0;
      r_hdir       <= 1'b1;
      r_vdir       <= 1'b1;
      r_dx         <= '0;
      r_dy         <= '0;
      r_nx         <= POS_W'(H_INIT);
      r_ny         <= POS_W'(V_INIT);
      r_hx         <= 1'b0;
      r_hy         <= 1'b0;
      ball_hpos    <= POS_W'(H_INIT);
      ball_vpos    <= POS_W'(V_INIT);
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      hit_h        <= 1'b0;
      hit_v        <= 1'b0;
      bounce_count <= '0;
    end else begin
      r_vsync    <= vsync;
      frame_done <= 1'b0;

      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_SAMPLE;
            busy    <= 1'b1;
          end
        end

        // Latch mode and derive the per-axis step for this frame.
        S_SAMPLE: begin
          r_auto <= mode_auto;
          if (mode_auto) begin
            r_dx <= r_hdir ? STEP : -STEP;
            r_dy <= r_vdir ? STEP : -STEP;
          end else begin
            r_dx <= left ? -STEP : (right ? STEP : '0);
            r_dy <= up   ? -STEP : (down  ? STEP : '0);
          end
          r_state <= S_MOVE_X;
        end

        // Clamp to the border; auto mode reflects direction on a clamp.
        S_MOVE_X: begin
          if (w_sum_x[STEP_W-1]) begin
            r_nx <= '0;
            r_hx <= 1'b1;
            if (r_auto) r_hdir <= 1'b1;
          end else if (w_sum_x > X_MAX) begin
            r_nx <= X_MAX[POS_W-1:0];
            r_hx <= 1'b1;
            if (r_auto) r_hdir <= 1'b0;
          end else begin
            r_nx <= w_sum_x[POS_W-1:0];
            r_hx <= 1'b0;
          end
          r_state <= S_MOVE_Y;
        end

        S_MOVE_Y: begin
          if (w_sum_y[STEP_W-1]) begin
            r_ny <= '0;
            r_hy <= 1'b1;
            if (r_auto) r_vdir <= 1'b1;
          end else if (w_sum_y > Y_MAX) begin
            r_ny <= Y_MAX[POS_W-1:0];
            r_hy <= 1'b1;
            if (r_auto) r_vdir <= 1'b0;
          end else begin
            r_ny <= w_sum_y[POS_W-1:0];
            r_hy <= 1'b0;
          end
          r_state <= S_COMMIT;
        end

        // Publish the new position and flags in one cycle.
        S_COMMIT: begin
          ball_hpos    <= r_nx;
          ball_vpos    <= r_ny;
          hit_h        <= r_hx;
          hit_v        <= r_hy;
          bounce_count <= bounce_count + CNT_W'(r_hx) + CNT_W'(r_hy);
          frame_done   <= 1'b1;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ball_frame_sequencer.sv
// Self-checking bench for ball_frame_sequencer: a table of manual/auto
// frames, hand-written corner sequences, and randomized frames compared
// against a frame-level reference model.
module tb_ball_frame_sequencer;

  localparam int H_ACTIVE  = 640;
  localparam int V_ACTIVE  = 480;
  localparam int BALL_SIZE = 8;
  localparam int SPEED     = 2;
  localparam int XMAX      = H_ACTIVE - BALL_SIZE;
  localparam int YMAX      = V_ACTIVE - BALL_SIZE;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       vsync = 1'b0;
  logic       mode_auto = 1'b0;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic [9:0] ball_hpos, ball_vpos;
  logic       busy, frame_done, hit_h, hit_v;
  logic [7:0] bounce_count;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (frame granularity).
  int m_x, m_y, m_bc;
  bit m_hdir, m_vdir, m_hx, m_hy;

  typedef struct {
    bit a, u, d, l, r;
    int h, v;
    bit hh, hv;
    int bc;
  } vec_t;

  vec_t tbl[8];

  ball_frame_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .vsync        (vsync),
    .mode_auto    (mode_auto),
    .up           (up),
    .down         (down),
    .left         (left),
    .right        (right),
    .ball_hpos    (ball_hpos),
    .ball_vpos    (ball_vpos),
    .busy         (busy),
    .frame_done   (frame_done),
    .hit_h        (hit_h),
    .hit_v        (hit_v),
    .bounce_count (bounce_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_x = 320; m_y = 240; m_bc = 0;
    m_hdir = 1'b1; m_vdir = 1'b1; m_hx = 1'b0; m_hy = 1'b0;
  endtask

  // One axis: move by d, clamp into [0, maxv], report whether clamped.
  task automatic axis(inout int pos, input int d, input int maxv, output bit hit);
    int n;
    n = pos + d;
    hit = 1'b0;
    if (n < 0) begin n = 0; hit = 1'b1; end
    else if (n > maxv) begin n = maxv; hit = 1'b1; end
    pos = n;
  endtask

  task automatic model_frame(input bit a, input bit u, input bit d, input bit l, input bit r);
    int dx, dy;
    if (a) begin
      dx = m_hdir ? SPEED : -SPEED;
      dy = m_vdir ? SPEED : -SPEED;
    end else begin
      dx = l ? -SPEED : (r ? SPEED : 0);
      dy = u ? -SPEED : (d ? SPEED : 0);
    end
    axis(m_x, dx, XMAX, m_hx);
    axis(m_y, dy, YMAX, m_hy);
    if (a && m_hx) m_hdir = (dx < 0);
    if (a && m_hy) m_vdir = (dy < 0);
    m_bc = (m_bc + int'(m_hx) + int'(m_hy)) % 256;
  endtask

  task automatic cmp_model(input string tag);
    chk({tag, " hpos"}, int'(ball_hpos), m_x);
    chk({tag, " vpos"}, int'(ball_vpos), m_y);
    chk({tag, " hit_h"}, int'(hit_h), int'(m_hx));
    chk({tag, " hit_v"}, int'(hit_v), int'(m_hy));
    chk({tag, " bounce_count"}, int'(bounce_count), m_bc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Run one frame: controls are applied, vsync rises, and the commit
  // latency is checked. With scramble set, controls change after SAMPLE.
  task automatic run_frame(input bit a, input bit u, input bit d, input bit l,
                           input bit r, input bit scramble);
    int k_done;
    k_done = -1;
    mode_auto = a; up = u; down = d; left = l; right = r;
    vsync = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk("busy after rise", int'(busy), 1);
      if (k == 2 && scramble) begin
        mode_auto = 1'($urandom); up = 1'($urandom); down = 1'($urandom);
        left = 1'($urandom); right = 1'($urandom);
      end
      if (frame_done) begin
        k_done = k;
        break;
      end
    end
    chk("commit latency", k_done, 5);
    chk("busy at commit", int'(busy), 0);
    vsync = 1'b0;
    model_frame(a, u, d, l, r);
  endtask

  initial begin
    int pulses, busy_seen, bc0;

    // Reset state.
    do_reset();
    chk("reset hpos", int'(ball_hpos), 320);
    chk("reset vpos", int'(ball_vpos), 240);
    chk("reset busy", int'(busy), 0);
    chk("reset frame_done", int'(frame_done), 0);
    chk("reset hits", int'({hit_h, hit_v}), 0);
    chk("reset bounce_count", int'(bounce_count), 0);

    // Table of manual/auto frames from reset.
    tbl[0] = '{0,0,0,0,0, 320,240, 0,0, 0};
    tbl[1] = '{0,0,1,0,1, 322,242, 0,0, 0};
    tbl[2] = '{0,0,0,1,1, 320,242, 0,0, 0};
    tbl[3] = '{0,1,1,0,0, 320,240, 0,0, 0};
    tbl[4] = '{0,1,0,1,0, 318,238, 0,0, 0};
    tbl[5] = '{0,0,0,0,1, 320,238, 0,0, 0};
    tbl[6] = '{0,0,1,0,0, 320,240, 0,0, 0};
    tbl[7] = '{1,1,0,1,0, 322,242, 0,0, 0};
    foreach (tbl[i]) begin
      run_frame(tbl[i].a, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r, 1'b0);
      chk($sformatf("tbl%0d hpos", i), int'(ball_hpos), tbl[i].h);
      chk($sformatf("tbl%0d vpos", i), int'(ball_vpos), tbl[i].v);
      chk($sformatf("tbl%0d hits", i), int'({hit_h, hit_v}), int'({tbl[i].hh, tbl[i].hv}));
      chk($sformatf("tbl%0d bounce_count", i), int'(bounce_count), tbl[i].bc);
    end

    // Manual right+down for 10 frames.
    do_reset();
    for (int i = 0; i < 10; i++) run_frame(0, 0, 1, 0, 1, 0);
    chk("rd10 hpos", int'(ball_hpos), 340);
    chk("rd10 vpos", int'(ball_vpos), 260);

    // Manual left+up into the corner: exact arrival is not a clamp,
    // then a frame that clamps both axes adds two bounces.
    do_reset();
    for (int i = 0; i < 160; i++) run_frame(0, 1, 0, 1, 0, 0);
    chk("corner arrive hpos", int'(ball_hpos), 0);
    chk("corner arrive hit_h", int'(hit_h), 0);
    cmp_model("corner arrive");
    bc0 = int'(bounce_count);
    run_frame(0, 1, 0, 1, 0, 0);
    chk("corner both hits", int'({hit_h, hit_v}), 3);
    chk("corner bounce +2", int'(bounce_count), (bc0 + 2) % 256);
    cmp_model("corner both");

    // Auto from reset: X reaches 632 after 156 frames, then clamps and reverses.
    do_reset();
    for (int i = 1; i <= 156; i++) begin
      run_frame(1, 0, 0, 0, 0, 0);
      if (i == 116 || i == 117) cmp_model($sformatf("auto%0d", i));
    end
    chk("auto156 hpos", int'(ball_hpos), 632);
    chk("auto156 hit_h", int'(hit_h), 0);
    run_frame(1, 0, 0, 0, 0, 0);
    chk("auto157 hpos", int'(ball_hpos), 632);
    chk("auto157 hit_h", int'(hit_h), 1);
    run_frame(1, 0, 0, 0, 0, 0);
    chk("auto158 hpos", int'(ball_hpos), 630);
    cmp_model("auto158");

    // Direction retained across a manual interlude.
    run_frame(0, 0, 0, 0, 0, 0);
    run_frame(1, 0, 0, 0, 0, 0);
    chk("auto resume hpos", int'(ball_hpos), 628);
    cmp_model("auto resume");

    // Second vsync rise while busy is dropped.
    vsync = 1'b0;
    mode_auto = 1'b0; up = 0; down = 0; left = 0; right = 1;
    @(posedge clk); #1;
    vsync = 1'b1;
    @(posedge clk); #1;
    vsync = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b1;
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      @(posedge clk); #1;
      if (frame_done) pulses++;
    end
    chk("dropped rise pulses", pulses, 1);
    model_frame(0, 0, 0, 0, 1);
    cmp_model("dropped rise");
    vsync = 1'b0;

    // Reset during MOVE_Y aborts the sequence.
    run_frame(0, 0, 1, 0, 1, 0);
    @(posedge clk); #1;
    vsync = 1'b1;
    @(posedge clk); #1;   // SAMPLE
    @(posedge clk); #1;   // MOVE_X
    @(posedge clk); #1;   // MOVE_Y
    chk("pre-abort busy", int'(busy), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    vsync = 1'b0;
    model_reset();
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (frame_done) pulses++;
      @(posedge clk); #1;
    end
    chk("abort pulses", pulses, 0);
    chk("abort busy", int'(busy), 0);
    cmp_model("abort");

    // vsync held high through reset release starts nothing.
    vsync = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_reset();
    busy_seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (busy || frame_done) busy_seen++;
    end
    chk("held vsync no start", busy_seen, 0);
    run_frame(0, 0, 0, 1, 0, 0);
    cmp_model("held vsync then frame");

    // Randomized frames against the reference model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bit a;
      a = ($urandom_range(0, 3) != 0);
      run_frame(a, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
      cmp_model($sformatf("rand%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ball_frame_sequencer.md
Name: ball_frame_sequencer

Overview:
Per-frame motion controller for the on-screen ball. On each vsync rising edge it runs a fixed 4-step sequence: sample the controls, step X with border clamp/bounce, step Y with border clamp/bounce, then commit. It drives the ball position consumed by the ball renderer and pixel/RGB logic, and supports manual (button-driven) and autonomous bounce modes. Position outputs change only at commit, never mid-frame.

Parameters:
H_ACTIVE, 640, visible width in pixels
V_ACTIVE, 480, visible height in pixels
BALL_SIZE, 8, ball edge length in pixels
SPEED, 2, pixels moved per frame per axis (1..BALL_SIZE)
H_INIT, 320, reset X position
V_INIT, 240, reset Y position

Ports:
clk  input  1  pixel clock
reset  input  1  synchronous, active-high reset
vsync  input  1  vertical sync from the video timing generator, active-high
mode_auto  input  1  1 = autonomous bounce, 0 = manual buttons
up  input  1  manual move up
down  input  1  manual move down
left  input  1  manual move left
right  input  1  manual move right
ball_hpos  output  10  committed ball X (left edge)
ball_vpos  output  10  committed ball Y (top edge)
busy  output  1  high while state != IDLE
frame_done  output  1  one-cycle pulse when a new position is committed
hit_h  output  1  last committed frame clamped on the X axis
hit_v  output  1  last committed frame clamped on the Y axis
bounce_count  output  8  count of axis clamps since reset, wraps 255->0

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on posedge clk.
- Reset values: ball_hpos=H_INIT, ball_vpos=V_INIT, busy=0, frame_done=0, hit_h=0, hit_v=0, bounce_count=0, state=IDLE, hdir=+ (right), vdir=+ (down). r_vsync is loaded with 1, so a vsync already high at reset release produces no edge.
- Edge detect: r_vsync <= vsync every cycle. rise = vsync & ~r_vsync.
- FSM states: IDLE -> SAMPLE -> MOVE_X -> MOVE_Y -> COMMIT -> IDLE. Each non-IDLE state lasts exactly one cycle.
- IDLE: on rise, go to SAMPLE. Otherwise stay.
- Rises seen in any non-IDLE state are dropped, not queued.
- SAMPLE: latch mode_auto and compute signed step dx, dy.
  - Manual mode: dx = -SPEED if left, else +SPEED if right, else 0. left wins when left and right are both set. dy works the same way with up winning over down.
  - Auto mode: dx = hdir ? +SPEED : -SPEED, dy = vdir ? +SPEED : -SPEED. Buttons are ignored.
  - mode_auto changes after SAMPLE have no effect until the next frame.
- MOVE_X: nx = {1'b0,ball_hpos} + sign-extended dx, computed 11-bit signed. Result goes to an internal holding register; outputs are not yet updated.
  - nx < 0: nx=0, hx=1, and in auto mode hdir<=+.
  - nx > H_ACTIVE-BALL_SIZE: nx=H_ACTIVE-BALL_SIZE, hx=1, and in auto mode hdir<=-.
  - Otherwise hx=0.
  - Exactly reaching 0 or H_ACTIVE-BALL_SIZE is not a clamp (hx=0).
- MOVE_Y: same rules with ny, V_ACTIVE, hy, vdir.
- COMMIT: ball_hpos<=nx, ball_vpos<=ny, hit_h<=hx, hit_v<=hy, bounce_count<=bounce_count+hx+hy (mod 256), frame_done<=1 for this cycle only.
- Latency: rise sampled at clock edge E0 puts the FSM in SAMPLE. Buttons are latched at E1. Outputs and the frame_done pulse become visible after E4. busy is high from after E0 until after E4.
- Manual mode leaves hdir/vdir unchanged, so the direction is retained when switching back to auto.
- Reset asserted mid-sequence aborts the sequence: no commit, and everything returns to reset values on the next edge.

Test Plan:
- Reset, manual, no buttons, 3 vsync pulses -> 3 frame_done pulses, each 4 clocks after the rise is sampled; position stays (320,240), bounce_count=0.
- Manual, right+down held, 10 frames -> (340,260); with left+right held the X step is -2 per frame (left wins).
- Manual, left held from hpos=1 -> after next frame hpos=0, hit_h=1, bounce_count=1; next frame hpos=0 again, bounce_count=2.
- Auto from reset, run until X clamp -> hpos reaches 632 after 156 frames, then decrements by 2; vpos clamps at 472 and reverses. On a frame where both axes clamp simultaneously, bounce_count increments by 2.
- vsync toggled high-low-high while busy -> second rise dropped, exactly one frame_done. Reset pulsed during MOVE_Y -> no frame_done, outputs (320,240), busy=0.
- vsync held high through reset release -> no sequence starts until vsync falls and rises again.
